// File: rtl/filtered_line_pkg.sv
// Shared types and constants for the filtered serial line transmitter.
package filtered_line_pkg;
    localparam int   FILTER_DEPTH   = 3;
    localparam int   MIN_BIT_CYCLES = FILTER_DEPTH + 1;
    localparam logic IDLE_LEVEL     = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;
endpackage

// File: rtl/filtered_line_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while enabled, flags the last count.
module filtered_line_bit_timer #(
    parameter int BIT_CYCLES = 4,
    parameter int TW         = $clog2(BIT_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic load,
    output logic bit_end
);
    logic [TW-1:0] count;

    assign bit_end = enable && (count == TW'(BIT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      count <= '0;
        else if (load)   count <= '0;
        else if (enable) count <= bit_end ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/filtered_line_tx.sv
// Serial transmitter holding each bit BIT_CYCLES clocks for a 3-sample far-end filter.
// Optional parity bit enabled by defining FILTERED_LINE_PARITY_EN.
module filtered_line_tx
    import filtered_line_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sig_out,
    output logic              busy,
    output logic              frame_done
);
    localparam int IW = $clog2(DATA_W + 1);

    if (BIT_CYCLES < MIN_BIT_CYCLES) begin : g_bit_cycles_check
        $error("filtered_line_tx: BIT_CYCLES must be >= MIN_BIT_CYCLES");
    end

    state_t            state, state_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [IW-1:0]     idx, idx_n;
    logic              bit_end, load, accept, sig_d;

    filtered_line_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .enable  (state != IDLE),
        .load    (load),
        .bit_end (bit_end)
    );

    assign tx_ready   = (state == IDLE) || (state == STOP && bit_end);
    assign accept     = tx_valid && tx_ready;
    assign busy       = (state != IDLE);
    assign frame_done = (state == STOP) && bit_end;

`ifdef FILTERED_LINE_PARITY_EN
    logic par_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      par_q <= 1'b0;
        else if (accept) par_q <= ^tx_data;
    end
`endif

    always_comb begin
        state_n = state;
        shift_n = shift;
        idx_n   = idx;
        load    = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_n = START;
                shift_n = tx_data;
                idx_n   = '0;
                load    = 1'b1;
            end
            START: if (bit_end) state_n = DATA;
            DATA: if (bit_end) begin
                shift_n = shift >> 1;
                if (idx == IW'(DATA_W - 1)) begin
                    idx_n = '0;
`ifdef FILTERED_LINE_PARITY_EN
                    state_n = PARITY;
`else
                    state_n = STOP;
`endif
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
`ifdef FILTERED_LINE_PARITY_EN
            PARITY: if (bit_end) state_n = STOP;
`endif
            STOP: if (bit_end) begin
                // Back-to-back accept in the last stop cycle skips IDLE entirely
                if (accept) begin
                    state_n = START;
                    shift_n = tx_data;
                    idx_n   = '0;
                    load    = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line level follows the next state so it changes on the same edge as the state
    always_comb begin
        sig_d = IDLE_LEVEL;
        case (state_n)
            START: sig_d = 1'b0;
            DATA:  sig_d = shift_n[0];
`ifdef FILTERED_LINE_PARITY_EN
            PARITY: sig_d = par_q;
`endif
            default: sig_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            idx     <= '0;
            sig_out <= IDLE_LEVEL;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            idx     <= idx_n;
            sig_out <= sig_d;
        end
    end
endmodule

// File: tb/tb_filtered_line_tx.sv
// Directed/table bench for filtered_line_tx, with a 3-sample glitch filter on the line.
module tb_filtered_line_tx;
    localparam int DW = 8;
    localparam int BC = 4;
`ifdef FILTERED_LINE_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int FL = NB * BC;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, sig_out, busy, frame_done;

    int checks = 0;
    int failures = 0;

    filtered_line_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
        .clock      (clock),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .sig_out    (sig_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    // Far-end filter: output follows the line after 3 equal consecutive samples
    logic [2:0] fsmp = 3'b111;
    logic       filt = 1'b1;
    always @(posedge clock) begin
        fsmp <= {fsmp[1:0], sig_out};
        if (fsmp[1] == sig_out && fsmp[0] == sig_out) filt <= sig_out;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          par;
        bit            more;
    } vec_t;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [DW-1:0] d, input logic par, input int b);
        if (b == 0) return 1'b0;
        if (b <= DW) return d[b-1];
`ifdef FILTERED_LINE_PARITY_EN
        if (b == DW + 1) return par;
`endif
        return 1'b1;
    endfunction

    // Caller has tx_valid=1, tx_data=d set and the DUT ready before the next edge.
    task automatic check_frame(input logic [DW-1:0] d, input logic par, input bit more,
                               input logic [DW-1:0] nd, input bit toggle);
        logic e;
        @(posedge clock); #1;
        if (more) tx_data = toggle ? DW'($urandom) : nd;
        else begin
            tx_valid = toggle;
            tx_data  = ~d;
        end
        for (int k = 0; k < FL; k++) begin
            @(negedge clock);
            e = bit_of(d, par, k / BC);
            chk("sig_out", sig_out, e);
            chk("busy", busy, 1'b1);
            chk("frame_done", frame_done, k == FL - 1);
            chk("tx_ready", tx_ready, k == FL - 1);
            if (k % BC == BC - 1) chk("filter_settled", filt, e);
            if (toggle) tx_data = (more && k == FL - 1) ? nd : DW'($urandom);
            if (!more && toggle && k == FL - 1) tx_valid = 1'b0;
        end
        if (!more) begin
            @(negedge clock);
            chk("idle_sig_out", sig_out, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_ready", tx_ready, 1'b1);
        end
    endtask

    vec_t vecs[7];
    logic [DW-1:0] w, nw;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h7F, 1'b1, 1'b0};

        #12;
        chk("rst_sig_out", sig_out, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        @(negedge clock); reset = 1'b1;
        @(negedge clock);
        chk("post_rst_sig_out", sig_out, 1'b1);

        // Table: single frames and back-to-back chains with valid held high
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || !vecs[i-1].more) begin
                tx_valid = 1'b1;
                tx_data  = vecs[i].data;
            end
            check_frame(vecs[i].data, vecs[i].par, vecs[i].more,
                        (i < 6) ? vecs[i+1].data : 8'h00, 1'b0);
        end

        // Data toggling after accept, valid held while busy, then a clean idle
        @(negedge clock);
        tx_valid = 1'b1; tx_data = 8'h96;
        check_frame(8'h96, 1'b0, 1'b1, 8'h4B, 1'b1);
        check_frame(8'h4B, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset mid-frame aborts at once; next frame is clean
        @(negedge clock);
        tx_valid = 1'b1; tx_data = 8'h5A;
        @(posedge clock); #1 tx_valid = 1'b0;
        repeat (16) @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("abort_sig_out", sig_out, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_frame_done", frame_done, 1'b0);
        @(negedge clock); reset = 1'b1;
        tx_valid = 1'b1; tx_data = 8'hC3;
        check_frame(8'hC3, 1'b0, 1'b0, 8'h00, 1'b0);

        // Random back-to-back loopback through the filter
        @(negedge clock);
        w = DW'($urandom);
        tx_valid = 1'b1; tx_data = w;
        for (int i = 0; i < 256; i++) begin
            nw = DW'($urandom);
            check_frame(w, ^w, i < 255, nw, 1'b0);
            w = nw;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
